toy_bus_ack_rr_arb: RTL

TOY_BUS_ACK_RR_ARB -- requirements
Module: toy_bus_ack_rr_arb

---
 rtl/toy_bus_ack_rr_arb_pkg.sv | 26 ++
 rtl/toy_bus_ack_rr_arb_if.sv | 24 ++
 rtl/toy_bus_pld_fifo2.sv | 57 +++++
 rtl/toy_bus_ack_rr_arb.sv | 104 ++++++++++
 4 files changed

// File: rtl/toy_bus_ack_rr_arb_pkg.sv
// Shared toy_bus package: ToyBusAck payload struct, default field widths and port-select type.
package toy_bus_ack_rr_arb_pkg;

   localparam int DEF_DATA_W = 256;
   localparam int DEF_SB_W   = 32;
   localparam int DEF_ID_W   = 4;

   typedef struct packed {
      logic                  opcode;
      logic [DEF_DATA_W-1:0] data;
      logic [DEF_SB_W-1:0]   sideband;
      logic [DEF_ID_W-1:0]   src_id;
      logic [DEF_ID_W-1:0]   tgt_id;
   } toy_bus_ack_t;

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_e;

   // Flattened payload width for a given field configuration.
   function automatic int pld_w(input int data_w, input int sb_w, input int id_w);
      return 1 + data_w + sb_w + 2 * id_w;
   endfunction

endpackage

// File: rtl/toy_bus_ack_rr_arb_if.sv
// ToyBusAck handshake + payload bundle; master drives vld/payload, slave drives rdy.
interface toy_bus_ack_rr_arb_if #(
   parameter int DATA_W = toy_bus_ack_rr_arb_pkg::DEF_DATA_W,
   parameter int SB_W   = toy_bus_ack_rr_arb_pkg::DEF_SB_W,
   parameter int ID_W   = toy_bus_ack_rr_arb_pkg::DEF_ID_W
);
   logic              vld;
   logic              rdy;
   logic              opcode;
   logic [DATA_W-1:0] data;
   logic [SB_W-1:0]   sideband;
   logic [ID_W-1:0]   src_id;
   logic [ID_W-1:0]   tgt_id;

   modport master (
      output vld, opcode, data, sideband, src_id, tgt_id,
      input  rdy
   );

   modport slave (
      input  vld, opcode, data, sideband, src_id, tgt_id,
      output rdy
   );
endinterface

// File: rtl/toy_bus_pld_fifo2.sv
// Two-entry payload FIFO; head register (ent0) directly feeds the consumer, full is registered state.
module toy_bus_pld_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         full,
   output logic         head_vld,
   output logic [W-1:0] head_data
);

   logic [1:0]   count;
   logic [W-1:0] ent0;
   logic [W-1:0] ent1;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 2'd0;
         ent0  <= '0;
         ent1  <= '0;
      end else begin
         case (count)
            2'd0: begin
               if (push) begin
                  ent0  <= push_data;
                  count <= 2'd1;
               end
            end
            2'd1: begin
               // Push with pop replaces the departing head, count stays 1.
               if (push && pop) begin
                  ent0 <= push_data;
               end else if (push) begin
                  ent1  <= push_data;
                  count <= 2'd2;
               end else if (pop) begin
                  count <= 2'd0;
               end
            end
            default: begin
               if (pop) begin
                  ent0  <= ent1;
                  count <= 2'd1;
               end
            end
         endcase
      end
   end

   assign full      = (count == 2'd2);
   assign head_vld  = (count != 2'd0);
   assign head_data = ent0;

endmodule

// File: rtl/toy_bus_ack_rr_arb.sv
// Two-input round-robin ToyBusAck merger with 2-entry output buffer.
// Optional per-input grant counters enabled by TOY_BUS_ACK_ARB_STAT_EN.
module toy_bus_ack_rr_arb
   import toy_bus_ack_rr_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int SB_W   = DEF_SB_W,
   parameter int ID_W   = DEF_ID_W
) (
   input  logic                  clk,
   input  logic                  rst,
   toy_bus_ack_rr_arb_if.slave   in0,
   toy_bus_ack_rr_arb_if.slave   in1,
   toy_bus_ack_rr_arb_if.master  out0
`ifdef TOY_BUS_ACK_ARB_STAT_EN
   ,
   output logic [15:0]           grant_cnt0,
   output logic [15:0]           grant_cnt1
`endif
);

   localparam int PLD_W = pld_w(DATA_W, SB_W, ID_W);

   port_e            ptr;
   logic             grant0;
   logic             grant1;
   logic             accept_ok;
   logic             push0;
   logic             push1;
   logic             push;
   logic             pop;
   logic             full;
   logic             head_vld;
   logic [PLD_W-1:0] pld0;
   logic [PLD_W-1:0] pld1;
   logic [PLD_W-1:0] push_pld;
   logic [PLD_W-1:0] head_pld;

   assign pld0 = {in0.opcode, in0.data, in0.sideband, in0.src_id, in0.tgt_id};
   assign pld1 = {in1.opcode, in1.data, in1.sideband, in1.src_id, in1.tgt_id};

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (in0.vld && in1.vld) begin
         grant0 = (ptr == PORT0);
         grant1 = (ptr == PORT1);
      end else begin
         grant0 = in0.vld;
         grant1 = in1.vld;
      end
   end

   // Capacity comes only from registered FIFO state, so out0.rdy never reaches inX.rdy.
   assign accept_ok = !full && !rst;
   assign in0.rdy   = grant0 && accept_ok;
   assign in1.rdy   = grant1 && accept_ok;

   assign push0    = in0.vld && in0.rdy;
   assign push1    = in1.vld && in1.rdy;
   assign push     = push0 || push1;
   assign push_pld = push1 ? pld1 : pld0;
   assign pop      = out0.vld && out0.rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= PORT0;
      end else if (push0) begin
         ptr <= PORT1;
      end else if (push1) begin
         ptr <= PORT0;
      end
   end

   toy_bus_pld_fifo2 #(
      .W (PLD_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_pld),
      .pop       (pop),
      .full      (full),
      .head_vld  (head_vld),
      .head_data (head_pld)
   );

   // Masking with rst guarantees no output handshake completes during reset.
   assign out0.vld = head_vld && !rst;
   assign {out0.opcode, out0.data, out0.sideband, out0.src_id, out0.tgt_id} = head_pld;

`ifdef TOY_BUS_ACK_ARB_STAT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt0 <= 16'd0;
         grant_cnt1 <= 16'd0;
      end else begin
         if (push0 && (grant_cnt0 != 16'hFFFF)) grant_cnt0 <= grant_cnt0 + 16'd1;
         if (push1 && (grant_cnt1 != 16'hFFFF)) grant_cnt1 <= grant_cnt1 + 16'd1;
      end
   end
`endif

endmodule
